// File: rtl/blake2_m_sched.sv
// blake2_m_sched: BLAKE2 message-word scheduler.
// Captures a 16-word message block on load. It then presents, one step at a
// time, the sigma-permuted word pairs (m0, m1) for NG parallel G functions.
// Each round has 8/NG steps: first the column half, then the diagonal half.
//
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   load            capture m and start a schedule (IDLE only)
//   m[16*WW]        message block, word i at [i*WW +: WW]
//   next            advance to the next step (ACTIVE only)
//   m0/m1[NG*WW]    first/second message word per slot, slot j at [j*WW +: WW]
//   round[4]        current round 0..ROUNDS-1
//   half            0 = column half, 1 = diagonal half
//   valid           m0/m1/round/half hold a valid step
//   done            one-cycle pulse after the final step is consumed
//
// Optional feature: define BLAKE2_M_SCHED_ZEROIZE_EN to clear the message
// register and m0/m1 when the schedule completes.
module blake2_m_sched #(
  parameter int unsigned WW     = 64,
  parameter int unsigned NG     = 4,
  parameter int unsigned ROUNDS = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [16*WW-1:0]   m,
  input  logic               next,
  output logic [NG*WW-1:0]   m0,
  output logic [NG*WW-1:0]   m1,
  output logic [3:0]         round,
  output logic               half,
  output logic               valid,
  output logic               done
);

  localparam int unsigned SPG     = 8 / NG;
  localparam int unsigned SPG_LOG = (SPG > 1) ? $clog2(SPG) : 0;
  localparam int unsigned TOTAL   = ROUNDS * SPG;
  localparam int unsigned STEP_W  = $clog2(TOTAL);
  localparam int unsigned LAST    = TOTAL - 1;
  localparam int unsigned MSG_W   = 16 * WW;
  localparam int unsigned OUT_W   = NG * WW;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state, state_n;
  logic [STEP_W-1:0]  step, step_n;
  logic [MSG_W-1:0]   msg, msg_n;
  logic [OUT_W-1:0]   m0_n, m1_n;
  logic [3:0]         round_n;
  logic               half_n, valid_n, done_n;

  // Step and block whose words the output registers will load this cycle
  logic               start_c;
  logic [STEP_W-1:0]  sel_step;
  logic [MSG_W-1:0]   sel_msg;
  logic [3:0]         sel_round, sel_row;
  logic [2:0]         sel_g, sel_base;
  logic               sel_half;
  logic [63:0]        sel_sigma;
  logic [OUT_W-1:0]   m0_sel, m1_sel;

  // Sigma permutation row, entry 0 in the most significant nibble
  function automatic logic [63:0] sigma_row(input logic [3:0] r);
    case (r)
      4'd0:    sigma_row = 64'h0123456789abcdef;
      4'd1:    sigma_row = 64'hea489fd61c02b753;
      4'd2:    sigma_row = 64'hb8c052fdae367194;
      4'd3:    sigma_row = 64'h7931dcbe265a40f8;
      4'd4:    sigma_row = 64'h905724afe1bc683d;
      4'd5:    sigma_row = 64'h2c6a0b834d75fe19;
      4'd6:    sigma_row = 64'hc51fed4a0763928b;
      4'd7:    sigma_row = 64'hdb7ec13950f4862a;
      4'd8:    sigma_row = 64'h6fe9b308c2d714a5;
      4'd9:    sigma_row = 64'ha2847615fb9e3cd0;
      default: sigma_row = 64'h0123456789abcdef;
    endcase
  endfunction

  // Word index at position p of a sigma row
  function automatic logic [3:0] sigma_nib(input logic [63:0] row,
                                           input logic [3:0]  p);
    logic [5:0] sh;
    sh = {4'd15 - p, 2'b00};
    sigma_nib = 4'(row >> sh);
  endfunction

  assign start_c  = (state == IDLE) && load;
  assign sel_step = start_c ? '0 : step + STEP_W'(1);
  assign sel_msg  = start_c ? m : msg;

  // Steps per round is a power of two, so divide/modulo are shift/mask
  assign sel_round = 4'(sel_step >> SPG_LOG);
  assign sel_g     = 3'(sel_step) & 3'(SPG - 1);
  assign sel_base  = 3'(sel_g * 3'(NG));
  assign sel_half  = sel_base[2];
  // Rounds 10 and 11 reuse sigma rows 0 and 1
  assign sel_row   = (sel_round >= 4'd10) ? sel_round - 4'd10 : sel_round;
  assign sel_sigma = sigma_row(sel_row);

  // Per-slot word selection through the sigma row
  for (genvar j = 0; j < NG; j++) begin : g_slot
    logic [1:0] gidx;
    logic [3:0] w0, w1;
    assign gidx = 2'(sel_base + 3'(j));
    assign w0   = sigma_nib(sel_sigma, {sel_half, gidx, 1'b0});
    assign w1   = sigma_nib(sel_sigma, {sel_half, gidx, 1'b1});
    assign m0_sel[j*WW +: WW] = sel_msg[32'(w0)*WW +: WW];
    assign m1_sel[j*WW +: WW] = sel_msg[32'(w1)*WW +: WW];
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      step  <= '0;
      msg   <= '0;
      m0    <= '0;
      m1    <= '0;
      round <= '0;
      half  <= 1'b0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      step  <= step_n;
      msg   <= msg_n;
      m0    <= m0_n;
      m1    <= m1_n;
      round <= round_n;
      half  <= half_n;
      valid <= valid_n;
      done  <= done_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n = state;
    step_n  = step;
    msg_n   = msg;
    m0_n    = m0;
    m1_n    = m1;
    round_n = round;
    half_n  = half;
    valid_n = valid;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (load) begin
          state_n = ACTIVE;
          step_n  = '0;
          msg_n   = m;
          m0_n    = m0_sel;
          m1_n    = m1_sel;
          round_n = sel_round;
          half_n  = sel_half;
          valid_n = 1'b1;
        end
      end
      ACTIVE: begin
        if (next) begin
          if (step == STEP_W'(LAST)) begin
            state_n = IDLE;
            valid_n = 1'b0;
            done_n  = 1'b1;
`ifdef BLAKE2_M_SCHED_ZEROIZE_EN
            msg_n   = '0;
            m0_n    = '0;
            m1_n    = '0;
`endif
          end else begin
            step_n  = sel_step;
            m0_n    = m0_sel;
            m1_n    = m1_sel;
            round_n = sel_round;
            half_n  = sel_half;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_blake2_m_sched.sv
// Directed bench for blake2_m_sched: a BLAKE2b-shaped instance (WW=64, NG=4,
// ROUNDS=12) and a BLAKE2s-shaped instance (WW=32, NG=1, ROUNDS=10).
// Expected words come from hand-evaluated sigma rows with m word i = i.
module tb_blake2_m_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Wide instance
  logic          rst_b, load_b, next_b;
  logic [1023:0] m_b;
  logic [255:0]  m0_b, m1_b;
  logic [3:0]    round_b;
  logic          half_b, valid_b, done_b;

  // Narrow instance
  logic          rst_s, load_s, next_s;
  logic [511:0]  m_s;
  logic [31:0]   m0_s, m1_s;
  logic [3:0]    round_s;
  logic          half_s, valid_s, done_s;

  int n_chk  = 0;
  int n_fail = 0;

  blake2_m_sched #(.WW(64), .NG(4), .ROUNDS(12)) u_dut_b (
    .clk(clk), .reset_n(rst_b), .load(load_b), .m(m_b), .next(next_b),
    .m0(m0_b), .m1(m1_b), .round(round_b), .half(half_b),
    .valid(valid_b), .done(done_b)
  );

  blake2_m_sched #(.WW(32), .NG(1), .ROUNDS(10)) u_dut_s (
    .clk(clk), .reset_n(rst_s), .load(load_s), .m(m_s), .next(next_s),
    .m0(m0_s), .m1(m1_s), .round(round_s), .half(half_s),
    .valid(valid_s), .done(done_s)
  );

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Four 64-bit slots, slot 0 in the low bits
  function automatic logic [255:0] p4(input int a, input int b,
                                      input int c, input int d);
    p4 = {64'(d), 64'(c), 64'(b), 64'(a)};
  endfunction

  task automatic fill_b(input int off);
    for (int i = 0; i < 16; i++) m_b[i*64 +: 64] = 64'(i + off);
  endtask

  // Called at a negedge: drive for one cycle, return at the next negedge
  task automatic drive_b(input logic ld, input logic nx);
    load_b = ld;
    next_b = nx;
    @(negedge clk);
    load_b = 1'b0;
    next_b = 1'b0;
  endtask

  task automatic drive_s(input logic ld, input logic nx);
    load_s = ld;
    next_s = nx;
    @(negedge clk);
    load_s = 1'b0;
    next_s = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; load_b = 1'b0; next_b = 1'b0; m_b = '0;
    rst_s = 1'b0; load_s = 1'b0; next_s = 1'b0; m_s = '0;
    #1;
    check("rst_valid", 256'(valid_b), 256'(0));
    check("rst_done",  256'(done_b),  256'(0));
    check("rst_m0",    m0_b,          256'(0));
    check("rst_round", 256'(round_b), 256'(0));
    @(negedge clk);
    rst_b = 1'b1;
    rst_s = 1'b1;
    @(negedge clk);

    // Step 0: round 0 column half
    fill_b(0);
    drive_b(1'b1, 1'b0);
    check("s0_valid", 256'(valid_b), 256'(1));
    check("s0_round", 256'(round_b), 256'(0));
    check("s0_half",  256'(half_b),  256'(0));
    check("s0_m0",    m0_b, p4(0, 2, 4, 6));
    check("s0_m1",    m1_b, p4(1, 3, 5, 7));

    // Step 1: diagonal half
    drive_b(1'b0, 1'b1);
    check("s1_half", 256'(half_b), 256'(1));
    check("s1_m0",   m0_b, p4(8, 10, 12, 14));
    check("s1_m1",   m1_b, p4(9, 11, 13, 15));

    // Step 2: round 1, sigma row 1
    drive_b(1'b0, 1'b1);
    check("s2_round", 256'(round_b), 256'(1));
    check("s2_half",  256'(half_b),  256'(0));
    check("s2_m0",    m0_b, p4(14, 4, 9, 13));
    check("s2_m1",    m1_b, p4(10, 8, 15, 6));

    // Load while active is ignored
    fill_b(100);
    drive_b(1'b1, 1'b0);
    check("ld_act_valid", 256'(valid_b), 256'(1));
    check("ld_act_round", 256'(round_b), 256'(1));
    check("ld_act_m0",    m0_b, p4(14, 4, 9, 13));
    drive_b(1'b0, 1'b1);
    check("s3_half", 256'(half_b), 256'(1));
    check("s3_m0",   m0_b, p4(1, 0, 11, 5));
    check("s3_m1",   m1_b, p4(12, 2, 7, 3));

    // Step 20: round 10 wraps to sigma row 0
    repeat (17) drive_b(1'b0, 1'b1);
    check("s20_round", 256'(round_b), 256'(10));
    check("s20_half",  256'(half_b),  256'(0));
    check("s20_m0",    m0_b, p4(0, 2, 4, 6));
    check("s20_m1",    m1_b, p4(1, 3, 5, 7));

    // Step 23: last step, round 11 uses row 1 diagonal
    repeat (3) drive_b(1'b0, 1'b1);
    check("s23_round", 256'(round_b), 256'(11));
    check("s23_half",  256'(half_b),  256'(1));
    check("s23_m0",    m0_b, p4(1, 0, 11, 5));
    check("s23_valid", 256'(valid_b), 256'(1));
    check("s23_done",  256'(done_b),  256'(0));

    // Final next: done pulse
    drive_b(1'b0, 1'b1);
    check("end_done",  256'(done_b),  256'(1));
    check("end_valid", 256'(valid_b), 256'(0));
`ifdef BLAKE2_M_SCHED_ZEROIZE_EN
    check("end_m0", m0_b, 256'(0));
    check("end_m1", m1_b, 256'(0));
`else
    check("end_m0", m0_b, p4(1, 0, 11, 5));
    check("end_m1", m1_b, p4(12, 2, 7, 3));
`endif
    drive_b(1'b0, 1'b0);
    check("done_once", 256'(done_b), 256'(0));

    // Next in IDLE is ignored
    drive_b(1'b0, 1'b1);
    check("idle_next_valid", 256'(valid_b), 256'(0));
    check("idle_next_done",  256'(done_b),  256'(0));

    // Load wins over next in IDLE; block now word i = i+100
    drive_b(1'b1, 1'b1);
    check("ldwin_valid", 256'(valid_b), 256'(1));
    check("ldwin_round", 256'(round_b), 256'(0));
    check("ldwin_half",  256'(half_b),  256'(0));
    check("ldwin_m0",    m0_b, p4(100, 102, 104, 106));

    // Load accepted in the cycle done is high
    repeat (23) drive_b(1'b0, 1'b1);
    drive_b(1'b0, 1'b1);
    check("done2", 256'(done_b), 256'(1));
    fill_b(0);
    drive_b(1'b1, 1'b0);
    check("ld_done_valid", 256'(valid_b), 256'(1));
    check("ld_done_done",  256'(done_b),  256'(0));
    check("ld_done_m0",    m0_b, p4(0, 2, 4, 6));

    // Step 5: round 2 diagonal, then asynchronous reset
    repeat (5) drive_b(1'b0, 1'b1);
    check("s5_round", 256'(round_b), 256'(2));
    check("s5_half",  256'(half_b),  256'(1));
    check("s5_m0",    m0_b, p4(10, 3, 7, 9));
    check("s5_m1",    m1_b, p4(14, 6, 1, 4));
    rst_b = 1'b0;
    #1;
    check("arst_valid", 256'(valid_b), 256'(0));
    check("arst_m0",    m0_b,          256'(0));
    check("arst_m1",    m1_b,          256'(0));
    check("arst_round", 256'(round_b), 256'(0));
    check("arst_half",  256'(half_b),  256'(0));
    @(negedge clk);
    rst_b = 1'b1;
    drive_b(1'b0, 1'b1);
    check("post_rst_valid", 256'(valid_b), 256'(0));
    check("post_rst_m0",    m0_b,          256'(0));

    // Narrow instance: 80 steps of one G each
    for (int i = 0; i < 16; i++) m_s[i*32 +: 32] = 32'(i);
    drive_s(1'b1, 1'b0);
    check("n0_valid", 256'(valid_s), 256'(1));
    check("n0_m0",    256'(m0_s),    256'(0));
    check("n0_m1",    256'(m1_s),    256'(1));
    repeat (4) drive_s(1'b0, 1'b1);
    check("n4_round", 256'(round_s), 256'(0));
    check("n4_half",  256'(half_s),  256'(1));
    check("n4_m0",    256'(m0_s),    256'(8));
    check("n4_m1",    256'(m1_s),    256'(9));
    repeat (4) drive_s(1'b0, 1'b1);
    check("n8_round", 256'(round_s), 256'(1));
    check("n8_half",  256'(half_s),  256'(0));
    check("n8_m0",    256'(m0_s),    256'(14));
    check("n8_m1",    256'(m1_s),    256'(10));
    repeat (71) drive_s(1'b0, 1'b1);
    check("n79_round", 256'(round_s), 256'(9));
    check("n79_m0",    256'(m0_s),    256'(13));
    check("n79_m1",    256'(m1_s),    256'(0));
    check("n79_valid", 256'(valid_s), 256'(1));
    check("n79_done",  256'(done_s),  256'(0));
    drive_s(1'b0, 1'b1);
    check("n_end_done",  256'(done_s),  256'(1));
    check("n_end_valid", 256'(valid_s), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/blake2_m_sched.md
BLAKE2_M_SCHED -- requirements
Module: blake2_m_sched

Interface
REQ-001 SHALL have parameter WW, default 64, message word width (64 = BLAKE2b, 32 = BLAKE2s).
REQ-002 SHALL have parameter NG, default 4, parallel G slots per step; legal values 1, 2, 4.
REQ-003 SHALL have parameter ROUNDS, default 12, compression rounds (12 = BLAKE2b, 10 = BLAKE2s).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port load  input  1  capture m and start a schedule.
REQ-007 SHALL have port m  input  16*WW  message block; word i at bits [i*WW +: WW].
REQ-008 SHALL have port next  input  1  advance to the next step.
REQ-009 SHALL have port m0  output  NG*WW  first message word per slot; slot j at [j*WW +: WW].
REQ-010 SHALL have port m1  output  NG*WW  second message word per slot, same packing.
REQ-011 SHALL have port round  output  4  current round number, 0..ROUNDS-1.
REQ-012 SHALL have port half  output  1  0 = column half, 1 = diagonal half.
REQ-013 SHALL have port valid  output  1  m0/m1/round/half hold a valid step.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final step is consumed.

Function
REQ-015 SHALL implement FSM states IDLE and ACTIVE.
REQ-016 SHALL, in IDLE with load=1, register m, set step=0, enter ACTIVE, and assert valid on the next cycle.
REQ-017 SHALL define steps per round as 8/NG; step s maps to round = s/(8/NG), group g = s mod (8/NG).
REQ-018 SHALL set half = (g*NG >= 4); G index for slot j = (g*NG + j) mod 4.
REQ-019 SHALL use sigma row (round mod 10) of the standard BLAKE2 table; G index k in half h selects word sigma[8h+2k] on m0 and sigma[8h+2k+1] on m1.
REQ-020 SHALL register m0, m1, round, and half; they update exactly one cycle after the load or next that selects them.
REQ-021 SHALL, in ACTIVE with next=1 and the step not the last, advance step by 1.
REQ-022 SHALL, in ACTIVE with next=1 on the last step (ROUNDS*8/NG-1), return to IDLE, drive valid=0, and pulse done=1 for one cycle.
REQ-023 SHALL ignore next in IDLE.
REQ-024 SHALL ignore load in ACTIVE; the captured block and the step are unchanged.
REQ-025 SHALL let load win over next when both are asserted in IDLE.
REQ-026 SHALL accept load in the same cycle done is high, since the FSM is then in IDLE.
REQ-027 SHALL map rounds 10 and 11 to sigma rows 0 and 1.

Reset
REQ-028 SHALL, on reset_n=0 and immediately regardless of clk, set the FSM to IDLE and clear step, the message register, m0, m1, round, half, valid, and done to 0.
REQ-029 SHALL, on reset mid-schedule, abandon the schedule; the first step after release requires a new load.

Configuration
REQ-030 SHALL support macro BLAKE2_M_SCHED_ZEROIZE_EN.
REQ-031 SHALL, with BLAKE2_M_SCHED_ZEROIZE_EN defined, clear the message register, m0, and m1 to 0 on the cycle the FSM returns to IDLE after the final step.
REQ-032 SHALL, without BLAKE2_M_SCHED_ZEROIZE_EN, retain the message register and last m0/m1 values in IDLE.

Verification
REQ-033 SHALL cover this scenario: NG=4, WW=64, m word i = i, load -> next cycle valid=1, round=0, half=0, m0 slots = {0,2,4,6}, m1 slots = {1,3,5,7}.
REQ-034 SHALL cover this scenario: same setup, next after step 0 -> half=1, m0 = {8,10,12,14}, m1 = {9,11,13,15}; next again -> round=1, half=0, m0 = {14,4,9,13}, m1 = {10,8,15,6}.
REQ-035 SHALL cover this scenario: NG=4, ROUNDS=12, 24 nexts -> round 10 shows m0 = {0,2,4,6}; done pulses once after the 24th next; valid=0 afterwards.
REQ-036 SHALL cover this scenario: NG=1, WW=32, ROUNDS=10 -> 80 steps; step 4 shows half=1, m0 = 8, m1 = 9; done after the 80th next.
REQ-037 SHALL cover this scenario: load asserted mid-schedule with a different m -> outputs continue from the original block; reset_n pulsed low at step 5 -> valid=0 and all outputs 0 immediately.
REQ-038 SHALL cover this scenario: with ZEROIZE_EN -> m0 = m1 = 0 after done; without it -> m0/m1 hold the last-step words.
